apb_cmd_initiator: RTL and testbench
====================================

Name: apb_cmd_initiator

Overview:
- APB initiator (bridge) that converts a simple valid/ready command stream into single APB3 transfers toward peripheral responders (timer, GPIO, etc.) on the peripheral bus.
- Returns a response record carrying read data, error and wait-state count through a valid/ready response channel.
- Sits between the core-side bus fabric and the APB peripheral segment.
- One outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 12, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- WAIT_CNT_WIDTH, 8, width of the wait-state counter reported in the response.
- TIMEOUT, 16, ACCESS-phase cycles allowed before abort (used only with the optional feature).

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_wait  out  WAIT_CNT_WIDTH  ACCESS cycles with PREADY=0, saturating.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock (HCLK); synchronous active-high reset (HRESET).
- Reset values: all outputs are registered and reset to 0.
  - cmd_ready=0 during reset; it goes to 1 in the first cycle after reset deasserts.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On handshake, latch write/addr/wdata into the APB registers, then go to SETUP.
- SETUP: exactly one cycle.
  - PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA valid.
  - Next state is ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, data and direction held stable.
  - When PREADY=1: sample PRDATA (reads only) and PSLVERR into the response registers, then go to RESP.
  - When PREADY=0: wait counter increments, saturating at all-ones.
- RESP:
  - rsp_valid=1; PSEL=0 and PENABLE=0.
  - Holds until rsp_ready=1, then returns to IDLE. rsp_valid clears in that same transition.
- Back-pressure: cmd_ready=0 in SETUP, ACCESS and RESP, so there is no new command until the response is consumed.
- Latency:
  - Handshake in cycle N → SETUP in N+1 → ACCESS in N+2.
  - With zero wait states, rsp_valid is high in N+3.
  - Each wait state adds one cycle.
- Idle bus values: after each transfer, PADDR, PWDATA and PWRITE return to 0; X is never driven.
- Write response: rsp_rdata=0 for writes.
- Error handling: PSLVERR is sampled only in the PREADY=1 cycle of ACCESS. PSLVERR in other cycles is ignored.
- Response stability: rsp_rdata, rsp_err and rsp_wait hold stable while rsp_valid=1.
- Reset mid-operation: the transfer is abandoned, no response is produced, the bus drops to idle next cycle, and the FSM returns to IDLE.
- Simultaneous rsp_ready and cmd_valid in RESP: the response is retired; the command is not accepted until the following IDLE cycle.

Optional Feature:
- Macro: APB_CMD_INITIATOR_TIMEOUT_EN.
- When defined:
  - An ACCESS-cycle counter aborts the transfer once TIMEOUT consecutive cycles pass with PREADY=0.
  - On abort: go to RESP with rsp_err=1, rsp_rdata=0 and rsp_wait=TIMEOUT (saturated); PSEL and PENABLE drop.
  - Timeout detection costs no extra cycle beyond the TIMEOUT-th ACCESS cycle.
- When undefined: ACCESS waits for PREADY indefinitely; no timeout counter logic is present.

Decomposition:
- Package apb_cmd_pkg:
  - FSM state enum (IDLE, SETUP, ACCESS, RESP).
  - Command struct {write, addr, wdata}.
  - Response struct {rdata, err, wait}.
  - Default width constants.
- Sub-module: apb_wait_counter, a saturating counter with clear and increment, plus a terminal-count compare used for the timeout. Everything else stays in the top module.

Test Plan:
- Zero-wait write: cmd write addr 0x008, data 0x00000001, PREADY tied 1 → PSEL rises N+1, PENABLE N+2, PADDR=0x008 and PWDATA=1 stable throughout; rsp_valid N+3 with rsp_err=0, rsp_wait=0, rsp_rdata=0.
- Wait-state read: read addr 0x004, responder holds PREADY=0 for 3 ACCESS cycles then PREADY=1 with PRDATA=0x00000009 → rsp_rdata=0x9, rsp_wait=3, rsp_valid at N+6.
- Slave error: write addr 0x000, responder returns PREADY=1 with PSLVERR=1 → rsp_err=1; next transfer with PSLVERR=0 → rsp_err=0.
- Back-pressure: rsp_ready=0 for 5 cycles with cmd_valid=1 held → cmd_ready stays 0 and rsp fields stay stable; rsp_ready=1 → IDLE, second command accepted one cycle later.
- Timeout (macro defined, TIMEOUT=16): read with PREADY held 0 → after 16 ACCESS cycles PSEL=0, rsp_err=1, rsp_wait=16, rsp_rdata=0. Macro undefined → still waiting after 100 cycles.
- Reset mid-ACCESS: assert HRESET for 1 cycle during wait states → next cycle PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=0; cmd_ready=1 one cycle after release, and a fresh write completes normally.

Source files
------------

// File: rtl/apb_cmd_pkg.sv
// Shared types and default widths for the APB command initiator.
package apb_cmd_pkg;

   localparam int ADDR_WIDTH_DEF     = 12;
   localparam int DATA_WIDTH_DEF     = 32;
   localparam int WAIT_CNT_WIDTH_DEF = 8;
   localparam int TIMEOUT_DEF        = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10,
      RESP   = 2'b11
   } state_e;

   typedef struct packed {
      logic                      write;
      logic [ADDR_WIDTH_DEF-1:0] addr;
      logic [DATA_WIDTH_DEF-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0]     rdata;
      logic                          err;
      logic [WAIT_CNT_WIDTH_DEF-1:0] wait_cnt;
   } rsp_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Saturating ACCESS wait-state counter with clear and increment.
// Build option APB_CMD_INITIATOR_TIMEOUT_EN adds the terminal-count flag tc_o.
module apb_wait_counter #(
   parameter int WIDTH = 8
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
   , parameter int TERMINAL = 16
`endif
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
   output logic             tc_o,
`endif
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
   // Fires during the TERMINAL-th stalled cycle so the abort costs no extra cycle.
   localparam logic [WIDTH-1:0] TC_LAST = WIDTH'(TERMINAL - 1);
   assign tc_o = inc_i && (cnt_q == TC_LAST);
`endif

   assign cnt_o = cnt_q;

endmodule

// File: rtl/apb_cmd_initiator.sv
// Valid/ready command stream to single APB3 transfers, one outstanding at a time.
// Build option APB_CMD_INITIATOR_TIMEOUT_EN enables the ACCESS-phase timeout abort.
module apb_cmd_initiator
   import apb_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int WAIT_CNT_WIDTH = WAIT_CNT_WIDTH_DEF
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
   , parameter int TIMEOUT      = TIMEOUT_DEF
`endif
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_err,
   output logic [WAIT_CNT_WIDTH-1:0] rsp_wait,
   output logic [ADDR_WIDTH-1:0]     PADDR,
   output logic [DATA_WIDTH-1:0]     PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [DATA_WIDTH-1:0]     PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   state_e                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  wait_clr_s;
   logic                  wait_inc_s;
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
   logic                  wait_tc_s;
`endif

   assign wait_clr_s = (state_q == IDLE);
   assign wait_inc_s = (state_q == ACCESS) && !PREADY;

   apb_wait_counter #(
      .WIDTH    (WAIT_CNT_WIDTH)
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
      , .TERMINAL (TIMEOUT)
`endif
   ) u_wait_counter (
      .clk_i (HCLK),
      .rst_i (HRESET),
      .clr_i (wait_clr_s),
      .inc_i (wait_inc_s),
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
      .tc_o  (wait_tc_s),
`endif
      .cnt_o (rsp_wait)
   );

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d  = SETUP;
               psel_d   = 1'b1;
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            // Leaving ACCESS always returns the bus to all-zero idle values.
            if (PREADY) begin
               state_d     = RESP;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
            end else if (wait_tc_s) begin
               state_d     = RESP;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
`endif
            end else begin
               state_d = ACCESS;
            end
            if (state_d == RESP) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               pwrite_d    = 1'b0;
               paddr_d     = '0;
               pwdata_d    = '0;
               rsp_valid_d = 1'b1;
            end else begin
               rsp_valid_d = 1'b0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d     = IDLE;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Self-checking bench for apb_cmd_initiator: scripted APB responder plus response scoreboard.
module tb_apb_cmd_initiator;
   import apb_cmd_pkg::*;

   logic        HCLK;
   logic        HRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  rsp_wait;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int          n_vec = 0;
   int          n_bad = 0;
   rsp_t        exp_q[$];

   int          cfg_waits = 0;
   logic [31:0] cfg_rdata = 32'h0000_0000;
   logic        cfg_err   = 1'b0;
   logic        cfg_noise = 1'b0;
   logic        cfg_hang  = 1'b0;
   int          acc_cnt   = 0;

   apb_cmd_initiator dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .rsp_wait  (rsp_wait),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PWRITE    (PWRITE),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // Responder: PREADY rises after cfg_waits stalled ACCESS cycles; PSLVERR noise outside ready cycle.
   initial begin
      PREADY  = 1'b0;
      PRDATA  = 32'h0000_0000;
      PSLVERR = 1'b0;
      forever begin
         @(negedge HCLK);
         if (PSEL === 1'b1 && PENABLE === 1'b1) acc_cnt++;
         else acc_cnt = 0;
         PREADY  = (acc_cnt > cfg_waits) && !cfg_hang;
         PRDATA  = PREADY ? cfg_rdata : 32'hDEAD_BEEF;
         PSLVERR = PREADY ? cfg_err : cfg_noise;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents a command, waits for acceptance, records the expected response, ends in cycle N+1.
   task automatic send(input cmd_t c, output int waited);
      rsp_t e;
      cmd_valid = 1'b1;
      cmd_write = c.write;
      cmd_addr  = c.addr;
      cmd_wdata = c.wdata;
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 50) begin
         @(negedge HCLK);
         waited++;
      end
      e.rdata    = c.write ? 32'h0000_0000 : cfg_rdata;
      e.err      = cfg_err;
      e.wait_cnt = (cfg_hang || cfg_waits > 255) ? 8'hFF : 8'(cfg_waits);
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
      if (cfg_hang || cfg_waits >= TIMEOUT_DEF) begin
         e.rdata    = 32'h0000_0000;
         e.err      = 1'b1;
         e.wait_cnt = 8'(TIMEOUT_DEF);
      end
`endif
      exp_q.push_back(e);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = ~c.addr;
      cmd_wdata = ~c.wdata;
   endtask

   task automatic wait_rsp(input int budget, output int cyc);
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < budget) begin
         @(negedge HCLK);
         cyc++;
      end
   endtask

   task automatic retire();
      rsp_ready = 1'b1;
      @(negedge HCLK);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      repeat (3) @(negedge HCLK);
      n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
      n_vec++; if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b00000) begin n_bad++; $display("FAIL rst_ctrl: got %b want 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}); end
      n_vec++; if ({PADDR, PWDATA, rsp_rdata, rsp_wait} !== 84'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {PADDR, PWDATA, rsp_rdata, rsp_wait}); end
      HRESET = 1'b0;
      @(negedge HCLK);
      n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %0b want 1", cmd_ready); end
   endtask

   task automatic test_zero_wait_write();
      cmd_t c;
      rsp_t e;
      int   w;
      cfg_waits = 0; cfg_rdata = 32'hA5A5_5A5A; cfg_err = 1'b0; cfg_noise = 1'b1;
      c = '{write: 1'b1, addr: 12'h008, wdata: 32'h0000_0001};
      send(c, w);
      n_vec++; if (w != 0) begin n_bad++; $display("FAIL zw_accept: got %0d want 0 wait cycles", w); end
      n_vec++; if ({PSEL, PENABLE, PWRITE, cmd_ready} !== 4'b1010) begin n_bad++; $display("FAIL zw_setup_ctrl: got %b want 1010", {PSEL, PENABLE, PWRITE, cmd_ready}); end
      n_vec++; if (PADDR !== 12'h008 || PWDATA !== 32'h0000_0001) begin n_bad++; $display("FAIL zw_setup_bus: got %h/%h want 008/00000001", PADDR, PWDATA); end
      @(negedge HCLK);
      n_vec++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin n_bad++; $display("FAIL zw_access_ctrl: got %b want 110", {PSEL, PENABLE, rsp_valid}); end
      n_vec++; if (PADDR !== 12'h008 || PWDATA !== 32'h0000_0001 || PWRITE !== 1'b1) begin n_bad++; $display("FAIL zw_access_bus: got %h/%h/%b want 008/00000001/1", PADDR, PWDATA, PWRITE); end
      @(negedge HCLK);
      n_vec++; if ({rsp_valid, PSEL, PENABLE} !== 3'b100) begin n_bad++; $display("FAIL zw_resp_ctrl: got %b want 100", {rsp_valid, PSEL, PENABLE}); end
      n_vec++; if (PADDR !== 12'h000 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin n_bad++; $display("FAIL zw_idle_bus: got %h/%h/%b want 0/0/0", PADDR, PWDATA, PWRITE); end
      e = exp_q.pop_front();
      n_vec++; if ({rsp_rdata, rsp_err, rsp_wait} !== {e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL zw_rsp: got %h/%b/%0d want %h/%b/%0d", rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
      retire();
      n_vec++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL zw_retire: got %b want 01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_wait_read();
      cmd_t c;
      rsp_t e;
      int   w;
      int   cyc;
      cfg_waits = 3; cfg_rdata = 32'h0000_0009; cfg_err = 1'b0; cfg_noise = 1'b1;
      c = '{write: 1'b0, addr: 12'h004, wdata: 32'hFFFF_FFFF};
      send(c, w);
      n_vec++; if (w != 0) begin n_bad++; $display("FAIL wr_accept: got %0d want 0 wait cycles", w); end
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 20) begin
         n_vec++; if (PSEL !== 1'b1 || PADDR !== 12'h004 || PWRITE !== 1'b0) begin n_bad++; $display("FAIL wr_hold_bus: got %b/%h/%b want 1/004/0", PSEL, PADDR, PWRITE); end
         @(negedge HCLK);
         cyc++;
      end
      n_vec++; if (cyc + 1 != 6) begin n_bad++; $display("FAIL wr_latency: got N+%0d want N+6", cyc + 1); end
      e = exp_q.pop_front();
      n_vec++; if ({rsp_rdata, rsp_err, rsp_wait} !== {e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL wr_rsp: got %h/%b/%0d want %h/%b/%0d", rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
      retire();
   endtask

   task automatic test_slave_error();
      cmd_t c;
      rsp_t e;
      int   w;
      int   cyc;
      cfg_waits = 1; cfg_rdata = 32'h0000_1234; cfg_err = 1'b1; cfg_noise = 1'b0;
      c = '{write: 1'b1, addr: 12'h000, wdata: 32'h0000_CAFE};
      send(c, w);
      wait_rsp(20, cyc);
      n_vec++; if (cyc + 1 != 4) begin n_bad++; $display("FAIL se_latency: got N+%0d want N+4", cyc + 1); end
      e = exp_q.pop_front();
      n_vec++; if ({rsp_rdata, rsp_err, rsp_wait} !== {e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL se_err_rsp: got %h/%b/%0d want %h/%b/%0d", rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
      retire();
      cfg_waits = 2; cfg_err = 1'b0; cfg_noise = 1'b1;
      c = '{write: 1'b1, addr: 12'h010, wdata: 32'h1357_9BDF};
      send(c, w);
      n_vec++; if (w != 0) begin n_bad++; $display("FAIL se_accept: got %0d want 0 wait cycles", w); end
      wait_rsp(20, cyc);
      e = exp_q.pop_front();
      n_vec++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_wait} !== {1'b1, e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL se_ok_rsp: got %b/%h/%b/%0d want 1/%h/%b/%0d", rsp_valid, rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
      retire();
   endtask

   task automatic test_back_to_back();
      cmd_t c1;
      cmd_t c2;
      rsp_t e;
      int   w;
      int   cyc;
      cfg_waits = 0; cfg_rdata = 32'h0000_0077; cfg_err = 1'b0; cfg_noise = 1'b0;
      c1 = '{write: 1'b0, addr: 12'h00C, wdata: 32'h0};
      c2 = '{write: 1'b1, addr: 12'h020, wdata: 32'h0000_0055};
      send(c1, w);
      wait_rsp(20, cyc);
      cmd_valid = 1'b1; cmd_write = c2.write; cmd_addr = c2.addr; cmd_wdata = c2.wdata;
      e = exp_q[0];
      for (int i = 0; i < 5; i++) begin
         n_vec++; if ({cmd_ready, rsp_valid} !== 2'b01) begin n_bad++; $display("FAIL bp_hold_ctrl[%0d]: got %b want 01", i, {cmd_ready, rsp_valid}); end
         n_vec++; if ({rsp_rdata, rsp_err, rsp_wait} !== {e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL bp_hold_rsp[%0d]: got %h/%b/%0d want %h/%b/%0d", i, rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
         @(negedge HCLK);
      end
      void'(exp_q.pop_front());
      retire();
      n_vec++; if ({rsp_valid, cmd_ready, PSEL} !== 3'b010) begin n_bad++; $display("FAIL bp_retire: got %b want 010", {rsp_valid, cmd_ready, PSEL}); end
      send(c2, w);
      n_vec++; if (w != 0) begin n_bad++; $display("FAIL bp_second_accept: got %0d want 0 wait cycles", w); end
      n_vec++; if (PSEL !== 1'b1 || PADDR !== 12'h020 || PWDATA !== 32'h0000_0055) begin n_bad++; $display("FAIL bp_second_setup: got %b/%h/%h want 1/020/00000055", PSEL, PADDR, PWDATA); end
      wait_rsp(20, cyc);
      e = exp_q.pop_front();
      n_vec++; if ({rsp_rdata, rsp_err, rsp_wait} !== {e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL bp_second_rsp: got %h/%b/%0d want %h/%b/%0d", rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
      retire();
   endtask

   task automatic test_timeout();
      cmd_t c;
      rsp_t e;
      int   w;
      int   cyc;
      cfg_waits = 0; cfg_rdata = 32'h3C3C_3C3C; cfg_err = 1'b0; cfg_noise = 1'b0; cfg_hang = 1'b1;
      c = '{write: 1'b0, addr: 12'h030, wdata: 32'h0};
      send(c, w);
`ifdef APB_CMD_INITIATOR_TIMEOUT_EN
      wait_rsp(40, cyc);
      n_vec++; if (cyc + 1 != TIMEOUT_DEF + 2) begin n_bad++; $display("FAIL to_latency: got N+%0d want N+%0d", cyc + 1, TIMEOUT_DEF + 2); end
      n_vec++; if ({rsp_valid, PSEL, PENABLE} !== 3'b100) begin n_bad++; $display("FAIL to_abort_ctrl: got %b want 100", {rsp_valid, PSEL, PENABLE}); end
      e = exp_q.pop_front();
      n_vec++; if ({rsp_rdata, rsp_err, rsp_wait} !== {e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL to_rsp: got %h/%b/%0d want %h/%b/%0d", rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
      cfg_hang = 1'b0;
      retire();
`else
      for (int i = 1; i <= TIMEOUT_DEF * 20; i++) begin
         @(negedge HCLK);
         if (i == 100) begin
            n_vec++; if ({rsp_valid, PSEL, PENABLE} !== 3'b011) begin n_bad++; $display("FAIL nto_still_waiting: got %b want 011", {rsp_valid, PSEL, PENABLE}); end
         end
      end
      cfg_hang = 1'b0;
      wait_rsp(10, cyc);
      e = exp_q.pop_front();
      n_vec++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_wait} !== {1'b1, e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL nto_sat_rsp: got %b/%h/%b/%0d want 1/%h/%b/%0d", rsp_valid, rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
      retire();
`endif
   endtask

   task automatic test_reset_mid_access();
      cmd_t c;
      rsp_t e;
      int   w;
      int   cyc;
      cfg_waits = 10; cfg_rdata = 32'h0; cfg_err = 1'b0; cfg_noise = 1'b0;
      c = '{write: 1'b1, addr: 12'h040, wdata: 32'h0000_1111};
      send(c, w);
      repeat (3) @(negedge HCLK);
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      void'(exp_q.pop_front());
      n_vec++; if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin n_bad++; $display("FAIL mr_reset_ctrl: got %b want 0000", {PSEL, PENABLE, rsp_valid, cmd_ready}); end
      n_vec++; if (PADDR !== 12'h000 || PWDATA !== 32'h0) begin n_bad++; $display("FAIL mr_reset_bus: got %h/%h want 0/0", PADDR, PWDATA); end
      @(negedge HCLK);
      n_vec++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL mr_release: got %b want 10", {cmd_ready, rsp_valid}); end
      cfg_waits = 0;
      c = '{write: 1'b1, addr: 12'h044, wdata: 32'h0000_BEEF};
      send(c, w);
      n_vec++; if (w != 0) begin n_bad++; $display("FAIL mr_accept: got %0d want 0 wait cycles", w); end
      wait_rsp(20, cyc);
      n_vec++; if (cyc + 1 != 3) begin n_bad++; $display("FAIL mr_latency: got N+%0d want N+3", cyc + 1); end
      e = exp_q.pop_front();
      n_vec++; if ({rsp_rdata, rsp_err, rsp_wait} !== {e.rdata, e.err, e.wait_cnt}) begin n_bad++; $display("FAIL mr_rsp: got %h/%b/%0d want %h/%b/%0d", rsp_rdata, rsp_err, rsp_wait, e.rdata, e.err, e.wait_cnt); end
      retire();
   endtask

   initial begin
      HRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 12'h000;
      cmd_wdata = 32'h0;
      rsp_ready = 1'b0;
      test_reset();
      test_zero_wait_write();
      test_wait_read();
      test_slave_error();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d entries want 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
